dvi_timing_ctrl: RTL and testbench

Sequences the three TMDS encoder channels of the DVI transmitter. Runs on the pixel clock and generates the raster position, the data-enable, hsync/vsync and the control-symbol inputs (C0/C1) for each channel. Also generates the running-disparity clear for each encoder. Sits between the pixel source (pattern generator or frame reader) and the per-channel 8b/10b TMDS encoders feeding the tmds_clk serialisers.

---
 rtl/dvi_timing_pkg.sv | 31 +++
 rtl/dvi_axis_counter.sv | 49 ++++
 rtl/dvi_timing_ctrl.sv | 121 ++++++++++++
 tb/tb_dvi_timing_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_timing_pkg.sv
// Timing constants, derived-position helpers and state type for the DVI
// timing controller. Defaults describe 640x480@60.
package dvi_timing_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;
   localparam int unsigned DEF_CNT_W    = 12;

   typedef enum logic {IDLE, RUN} state_t;

   function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int unsigned sync_start(input int unsigned active, input int unsigned fp);
      return active + fp;
   endfunction

   function automatic int unsigned sync_end(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync);
      return active + fp + sync;
   endfunction

endpackage

// File: rtl/dvi_axis_counter.sv
// One raster axis: wrapping position counter plus decode of the value it
// will hold after the next edge, so the caller can register aligned flags.
module dvi_axis_counter
   import dvi_timing_pkg::*;
#(
   parameter int unsigned CNT_W      = 12,
   parameter int unsigned TOTAL      = 800,
   parameter int unsigned ACTIVE     = 640,
   parameter int unsigned SYNC_START = 656,
   parameter int unsigned SYNC_END   = 752
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             adv,
   output logic [CNT_W-1:0] cnt,
   output logic             last,
   output logic             act_nxt,
   output logic             sync_nxt,
   output logic             zero_nxt
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

   logic [CNT_W-1:0] cnt_nxt;
   logic [31:0]      nxt_w;

   assign last = (cnt == LAST);

   // Next position: clear wins, otherwise advance with wrap at TOTAL-1.
   always_comb begin
      cnt_nxt = cnt;
      if (clr) begin
         cnt_nxt = '0;
      end else if (adv) begin
         cnt_nxt = last ? '0 : cnt + CNT_W'(1);
      end
   end

   assign nxt_w    = 32'(cnt_nxt);
   assign act_nxt  = (nxt_w < ACTIVE);
   assign sync_nxt = (nxt_w >= SYNC_START) && (nxt_w < SYNC_END);
   assign zero_nxt = (cnt_nxt == '0);

   // Position register.
   always_ff @(posedge clk) begin
      cnt <= cnt_nxt;
   end

endmodule

// File: rtl/dvi_timing_ctrl.sv
// Raster timing and TMDS control-symbol sequencing for the three DVI
// encoder channels. All outputs are registered and aligned with x/y.
module dvi_timing_ctrl
   import dvi_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter logic        H_POL    = 1'b0,
   parameter logic        V_POL    = 1'b0,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic             pix_clk,
   input  logic             rst,
   input  logic             en,
   output logic             busy,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             de,
   output logic             hsync,
   output logic             vsync,
   output logic [1:0]       ctrl_b,
   output logic [1:0]       ctrl_g,
   output logic [1:0]       ctrl_r,
   output logic             bitcnt_clr,
   output logic             line_start,
   output logic             frame_start
);

   localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
      $error("dvi_timing_ctrl: sync widths must be non-zero");
   end
   if (((H_TOTAL - 1) >> CNT_W) != 0 || ((V_TOTAL - 1) >> CNT_W) != 0) begin : g_bad_width
      $error("dvi_timing_ctrl: CNT_W too narrow for H_TOTAL/V_TOTAL");
   end

   state_t state, state_nxt;
   logic   cnt_clr;
   logic   h_last, h_act, h_sync, h_zero;
   logic   v_last, v_act, v_sync, v_zero;
   logic   run_n, de_n, hs_lvl, vs_lvl;

   // Counters sit at zero whenever the next cycle is not part of a running
   // frame continuation; at frame end they wrap to zero on their own.
   assign cnt_clr = rst || (state == IDLE);

   dvi_axis_counter #(
      .CNT_W(CNT_W), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
      .SYNC_START(sync_start(H_ACTIVE, H_FP)), .SYNC_END(sync_end(H_ACTIVE, H_FP, H_SYNC))
   ) u_h (
      .clk(pix_clk), .clr(cnt_clr), .adv(1'b1), .cnt(x),
      .last(h_last), .act_nxt(h_act), .sync_nxt(h_sync), .zero_nxt(h_zero)
   );

   dvi_axis_counter #(
      .CNT_W(CNT_W), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
      .SYNC_START(sync_start(V_ACTIVE, V_FP)), .SYNC_END(sync_end(V_ACTIVE, V_FP, V_SYNC))
   ) u_v (
      .clk(pix_clk), .clr(cnt_clr), .adv(h_last), .cnt(y),
      .last(v_last), .act_nxt(v_act), .sync_nxt(v_sync), .zero_nxt(v_zero)
   );

   // Frame sequencing: en starts a frame from IDLE and is otherwise only
   // looked at on the last pixel of a frame.
   always_comb begin
      state_nxt = state;
      if (rst) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (h_last && v_last && !en) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign run_n  = (state_nxt == RUN);
   assign de_n   = run_n && h_act && v_act;
   assign hs_lvl = (run_n && h_sync) ? H_POL : ~H_POL;
   assign vs_lvl = (run_n && v_sync) ? V_POL : ~V_POL;

   // State and output registers, decoded from the upcoming position so
   // every output lines up with the x/y shown in the same cycle.
   always_ff @(posedge pix_clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         de          <= 1'b0;
         hsync       <= ~H_POL;
         vsync       <= ~V_POL;
         ctrl_b      <= {~V_POL, ~H_POL};
         ctrl_g      <= '0;
         ctrl_r      <= '0;
         bitcnt_clr  <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nxt;
         busy        <= run_n;
         de          <= de_n;
         hsync       <= hs_lvl;
         vsync       <= vs_lvl;
         ctrl_b      <= {vs_lvl, hs_lvl};
         ctrl_g      <= '0;
         ctrl_r      <= '0;
         bitcnt_clr  <= ~de_n;
         line_start  <= run_n && h_zero;
         frame_start <= run_n && h_zero && v_zero;
      end
   end

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Self-checking bench: a small-parameter instance driven from a vector
// table, and a default-horizontal instance with shortened vertical timing
// exercised by hand-written multi-cycle sequences.
module tb_dvi_timing_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Instance A: default horizontal timing, 4/2/2/3 vertical (11 lines).
   logic        rst_a, en_a, busy_a, de_a, hs_a, vs_a, bc_a, ls_a, fs_a;
   logic [11:0] x_a, y_a;
   logic [1:0]  cb_a, cg_a, cr_a;

   // Instance B: tiny raster 8x5, active-high syncs.
   logic        rst_b, en_b, busy_b, de_b, hs_b, vs_b, bc_b, ls_b, fs_b;
   logic [11:0] x_b, y_b;
   logic [1:0]  cb_b, cg_b, cr_b;

   dvi_timing_ctrl #(
      .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) u_a (
      .pix_clk(clk), .rst(rst_a), .en(en_a), .busy(busy_a), .x(x_a), .y(y_a),
      .de(de_a), .hsync(hs_a), .vsync(vs_a), .ctrl_b(cb_a), .ctrl_g(cg_a),
      .ctrl_r(cr_a), .bitcnt_clr(bc_a), .line_start(ls_a), .frame_start(fs_a)
   );

   dvi_timing_ctrl #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b1)
   ) u_b (
      .pix_clk(clk), .rst(rst_b), .en(en_b), .busy(busy_b), .x(x_b), .y(y_b),
      .de(de_b), .hsync(hs_b), .vsync(vs_b), .ctrl_b(cb_b), .ctrl_g(cg_b),
      .ctrl_r(cr_b), .bitcnt_clr(bc_b), .line_start(ls_b), .frame_start(fs_b)
   );

   typedef struct {
      logic rst;
      logic en;
      logic busy;
      int   x;
      int   y;
      logic de;
      logic hs;
      logic vs;
      logic ls;
      logic fs;
   } vec_t;

   vec_t tbl[11];

   function automatic vec_t mk(input logic rst, input logic en, input logic busy,
                               input int x, input int y, input logic de, input logic hs,
                               input logic vs, input logic ls, input logic fs);
      vec_t v;
      v.rst = rst; v.en = en; v.busy = busy; v.x = x; v.y = y;
      v.de = de; v.hs = hs; v.vs = vs; v.ls = ls; v.fs = fs;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n, bad, vs_hi, vs_bad, hs_bad, ctl_bad;
      int de_cnt, hs0_cnt, hs8_cnt, hs_first, hs_last, vs_cnt, ls_cnt, ls_bad, last_ls;
      int fs_cnt, rng_bad, side_bad, de_bad, px, py;

      rst_a = 1'b1; en_a = 1'b0;
      rst_b = 1'b1; en_b = 1'b0;

      //           rst en busy x  y de hs vs ls fs
      tbl[0]  = mk(1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      tbl[2]  = mk(0, 1, 1,   0, 0, 1, 0, 0, 1, 1);
      tbl[3]  = mk(0, 1, 1,   1, 0, 1, 0, 0, 0, 0);
      tbl[4]  = mk(0, 1, 1,   2, 0, 1, 0, 0, 0, 0);
      tbl[5]  = mk(0, 1, 1,   3, 0, 1, 0, 0, 0, 0);
      tbl[6]  = mk(0, 1, 1,   4, 0, 0, 0, 0, 0, 0);
      tbl[7]  = mk(0, 1, 1,   5, 0, 0, 1, 0, 0, 0);
      tbl[8]  = mk(0, 1, 1,   6, 0, 0, 1, 0, 0, 0);
      tbl[9]  = mk(0, 1, 1,   7, 0, 0, 0, 0, 0, 0);
      tbl[10] = mk(0, 1, 1,   0, 1, 1, 0, 0, 1, 0);

      // ---------------- instance B: table-driven start of frame ----------
      for (int i = 0; i < 11; i++) begin
         rst_b = tbl[i].rst;
         en_b  = tbl[i].en;
         step();
         chk($sformatf("b_busy[%0d]", i), int'(busy_b), int'(tbl[i].busy));
         chk($sformatf("b_x[%0d]", i),    int'(x_b),    tbl[i].x);
         chk($sformatf("b_y[%0d]", i),    int'(y_b),    tbl[i].y);
         chk($sformatf("b_de[%0d]", i),   int'(de_b),   int'(tbl[i].de));
         chk($sformatf("b_hs[%0d]", i),   int'(hs_b),   int'(tbl[i].hs));
         chk($sformatf("b_vs[%0d]", i),   int'(vs_b),   int'(tbl[i].vs));
         chk($sformatf("b_ls[%0d]", i),   int'(ls_b),   int'(tbl[i].ls));
         chk($sformatf("b_fs[%0d]", i),   int'(fs_b),   int'(tbl[i].fs));
         chk($sformatf("b_side[%0d]", i),
             int'({cb_b, cg_b, cr_b, bc_b}),
             int'({tbl[i].vs, tbl[i].hs, 4'b0000, ~tbl[i].de}));
      end

      // Instance B: drop en mid-frame (at x=0,y=1), frame runs out.
      en_b = 1'b0;
      n = 0; vs_hi = 0; vs_bad = 0; hs_bad = 0; ctl_bad = 0;
      while (busy_b && n < 100) begin
         step();
         n++;
         if (vs_b) begin
            vs_hi++;
            if (y_b != 12'd3) vs_bad++;
         end
         if (hs_b != (x_b == 12'd5 || x_b == 12'd6)) hs_bad++;
         if (cb_b != {vs_b, hs_b} || cg_b != 2'b00 || cr_b != 2'b00) ctl_bad++;
      end
      chk("b_tail_len", n, 32);
      chk("b_vsync_cycles", vs_hi, 8);
      chk("b_vsync_line", vs_bad, 0);
      chk("b_hsync_window", hs_bad, 0);
      chk("b_ctrl", ctl_bad, 0);
      chk("b_idle_xy", int'({x_b, y_b}), 0);

      // Instance B: back-to-back frame length.
      en_b = 1'b1;
      step();
      chk("b_restart_fs", int'(fs_b), 1);
      n = 0;
      do begin
         step();
         n++;
      end while (!fs_b && n < 100);
      chk("b_frame_len", n, 40);
      rst_b = 1'b1;

      // ---------------- instance A: idle hold after reset ----------------
      step();
      rst_a = 1'b0;
      bad = 0;
      repeat (10) begin
         step();
         if (busy_a || x_a != 0 || y_a != 0 || de_a || !hs_a || !vs_a || !bc_a ||
             ls_a || fs_a || cb_a != 2'b11 || cg_a != 2'b00 || cr_a != 2'b00) bad++;
      end
      chk("a_idle_hold", bad, 0);
      chk("a_idle_hsync", int'(hs_a), 1);
      chk("a_idle_vsync", int'(vs_a), 1);
      chk("a_idle_de", int'(de_a), 0);
      chk("a_idle_bclr", int'(bc_a), 1);

      // Instance A: first cycle of a frame.
      en_a = 1'b1;
      step();
      chk("a_start_busy", int'(busy_a), 1);
      chk("a_start_x", int'(x_a), 0);
      chk("a_start_y", int'(y_a), 0);
      chk("a_start_de", int'(de_a), 1);
      chk("a_start_fs", int'(fs_a), 1);
      chk("a_start_ls", int'(ls_a), 1);
      chk("a_start_bclr", int'(bc_a), 0);

      // Instance A: one whole frame (800 x 11 = 8800 cycles).
      de_cnt = 0; hs0_cnt = 0; hs8_cnt = 0; hs_first = -1; hs_last = -1;
      vs_cnt = 0; vs_bad = 0; ls_cnt = 0; ls_bad = 0; last_ls = 0;
      fs_cnt = 0; rng_bad = 0; side_bad = 0; de_bad = 0;
      for (int i = 0; i < 8800; i++) begin
         if (de_a) de_cnt++;
         if (!hs_a && y_a == 12'd0) begin
            hs0_cnt++;
            if (hs_first < 0) hs_first = int'(x_a);
            hs_last = int'(x_a);
         end
         if (!hs_a && y_a == 12'd8) hs8_cnt++;
         if (!vs_a) begin
            vs_cnt++;
            if (y_a != 12'd6 && y_a != 12'd7) vs_bad++;
         end
         if (ls_a) begin
            ls_cnt++;
            if (x_a != 0 || (i != 0 && i - last_ls != 800)) ls_bad++;
            last_ls = i;
         end
         if (fs_a) fs_cnt++;
         if (x_a > 12'd799 || y_a > 12'd10 || !busy_a) rng_bad++;
         if (bc_a != !de_a || cb_a != {vs_a, hs_a} || cg_a != 2'b00 || cr_a != 2'b00) side_bad++;
         if (de_a != (x_a < 12'd640 && y_a < 12'd4)) de_bad++;
         step();
      end
      chk("a_de_cycles", de_cnt, 2560);
      chk("a_de_window", de_bad, 0);
      chk("a_hsync_len", hs0_cnt, 96);
      chk("a_hsync_first", hs_first, 656);
      chk("a_hsync_last", hs_last, 751);
      chk("a_hsync_vblank", hs8_cnt, 96);
      chk("a_vsync_cycles", vs_cnt, 1600);
      chk("a_vsync_lines", vs_bad, 0);
      chk("a_line_starts", ls_cnt, 11);
      chk("a_line_period", ls_bad, 0);
      chk("a_frame_starts", fs_cnt, 1);
      chk("a_range", rng_bad, 0);
      chk("a_side", side_bad, 0);
      chk("a_next_fs", int'(fs_a), 1);
      chk("a_next_xy", int'({x_a, y_a}), 0);

      // Instance A: drop en on line 5, frame must complete.
      n = 0;
      while (y_a != 12'd5 && n < 20000) begin
         step();
         n++;
      end
      chk("a_reach_y5", int'(y_a), 5);
      en_a = 1'b0;
      n = 0; px = -1; py = -1;
      while (busy_a && n < 20000) begin
         px = int'(x_a);
         py = int'(y_a);
         step();
         n++;
      end
      chk("a_stop_busy", int'(busy_a), 0);
      chk("a_stop_last_x", px, 799);
      chk("a_stop_last_y", py, 10);
      chk("a_stop_xy", int'({x_a, y_a}), 0);
      bad = 0;
      repeat (20) begin
         step();
         if (fs_a || busy_a || x_a != 0 || y_a != 0) bad++;
      end
      chk("a_stay_idle", bad, 0);

      // Instance A: reset mid-frame with en held high.
      en_a = 1'b1;
      step();
      chk("a_restart_fs", int'(fs_a), 1);
      n = 0;
      while (!(x_a == 12'd300 && y_a == 12'd3) && n < 20000) begin
         step();
         n++;
      end
      chk("a_reach_300_3", int'({x_a, y_a}), int'({12'd300, 12'd3}));
      rst_a = 1'b1;
      step();
      chk("a_rst_busy", int'(busy_a), 0);
      chk("a_rst_xy", int'({x_a, y_a}), 0);
      chk("a_rst_outs", int'({de_a, hs_a, vs_a, bc_a, ls_a, fs_a, cb_a}),
          int'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11}));
      rst_a = 1'b0;
      step();
      chk("a_rst_restart_busy", int'(busy_a), 1);
      chk("a_rst_restart_xy", int'({x_a, y_a}), 0);
      chk("a_rst_restart_fs", int'(fs_a), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
